ysyx_22040931_mem_arb: RTL and testbench

- Single-outstanding arbiter/sequencer sharing one memory port between instruction fetch (IF) and the MEM-stage load/store unit (LS).
- Sits between the fetch unit / MEM stage and the memory bus.
- Latches the winning request and generates byte strobes from size and address.
- Runs the request/response handshake, with alignment checking and a response timeout.

---
 rtl/ysyx_22040931_mem_arb_pkg.sv | 29 ++
 rtl/ysyx_22040931_mem_strb.sv | 26 ++
 rtl/ysyx_22040931_mem_arb.sv | 183 ++++++++++++++++++
 tb/tb_ysyx_22040931_mem_arb.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040931_mem_arb_pkg.sv
// Shared codes for the IF/LS memory arbiter: access sizes, bus widths,
// arbiter state encoding and request owner codes.
package ysyx_22040931_mem_arb_pkg;

    localparam int MEM_BUS  = 32;
    localparam int DATA_BUS = 64;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_own_e;

    function automatic logic [2:0] size_mask(input logic [1:0] size);
        return 3'((4'd1 << size) - 4'd1);
    endfunction

endpackage

// File: rtl/ysyx_22040931_mem_strb.sv
// Byte-strobe and misalignment generator for one access
// described by size and the low address bits.
module ysyx_22040931_mem_strb
    import ysyx_22040931_mem_arb_pkg::*;
#(
    parameter int SW = 8
) (
    input  logic          wr_i,
    input  logic [1:0]    size_i,
    input  logic [2:0]    off_i,
    output logic [SW-1:0] wstrb_o,
    output logic          misal_o
);

    always_comb begin
        wstrb_o = '0;
        // Lanes beyond SW fall off, matching the truncated shift.
        for (int i = 0; i < SW; i++) begin
            wstrb_o[i] = wr_i
                && (i >= int'(off_i))
                && (i < int'(off_i) + (1 << size_i));
        end
        misal_o = |(off_i & size_mask(size_i));
    end

endmodule

// File: rtl/ysyx_22040931_mem_arb.sv
// Single-outstanding arbiter sharing one memory port between
// instruction fetch and the load/store unit (LS has priority).
module ysyx_22040931_mem_arb
    import ysyx_22040931_mem_arb_pkg::*;
#(
    parameter int AW      = MEM_BUS,
    parameter int DW      = DATA_BUS,
    parameter int TIMEOUT = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req_i,
    input  logic [AW-1:0]   if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [DW-1:0]   if_rdata_o,
    output logic            if_err_o,
    input  logic            ls_req_i,
    input  logic            ls_wr_i,
    input  logic [1:0]      ls_size_i,
    input  logic [AW-1:0]   ls_addr_i,
    input  logic [DW-1:0]   ls_wdata_i,
    output logic            ls_gnt_o,
    output logic            ls_rvalid_o,
    output logic [DW-1:0]   ls_rdata_o,
    output logic            ls_err_o,
    output logic            mem_req_o,
    output logic            mem_wr_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    output logic [DW/8-1:0] mem_wstrb_o,
    input  logic            mem_ready_i,
    input  logic            mem_rvalid_i,
    input  logic [DW-1:0]   mem_rdata_i,
    output logic            busy_o
);

    localparam int SW = DW / 8;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_e      state_q, state_d;
    arb_own_e        own_q;
    logic [AW-1:0]   addr_q;
    logic            wr_q;
    logic [DW-1:0]   wdata_q;
    logic [SW-1:0]   strb_q;
    logic [DW-1:0]   rdata_q;
    logic            err_q;
    logic [CW-1:0]   cnt_q;

    logic            any_req;
    logic            sel_wr;
    logic [1:0]      sel_size;
    logic [2:0]      sel_off;
    logic [SW-1:0]   sel_strb;
    logic            sel_misal;
    logic            done;
    logic            tmo;
    logic            tmo_hit;

    // IF always fetches an aligned doubleword read.
    assign any_req  = ls_req_i | if_req_i;
    assign sel_wr   = ls_req_i & ls_wr_i;
    assign sel_size = ls_req_i ? ls_size_i : SIZE_D;
    assign sel_off  = ls_req_i ? ls_addr_i[2:0] : 3'd0;

    ysyx_22040931_mem_strb #(
        .SW(SW)
    ) u_strb (
        .wr_i    (sel_wr),
        .size_i  (sel_size),
        .off_i   (sel_off),
        .wstrb_o (sel_strb),
        .misal_o (sel_misal)
    );

    assign tmo_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
    assign done = ((state_q == ST_REQ) && mem_ready_i && mem_rvalid_i)
               || ((state_q == ST_WAIT) && mem_rvalid_i);
    assign tmo  = ((state_q == ST_REQ) || (state_q == ST_WAIT))
               && !done && tmo_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ls_req_i) begin
                    state_d = sel_misal ? ST_RESP : ST_REQ;
                end else if (if_req_i) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (done || tmo) begin
                    state_d = ST_RESP;
                end else if (mem_ready_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (done || tmo) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_q   <= OWN_IF;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if ((state_q == ST_IDLE) && any_req) begin
                own_q   <= ls_req_i ? OWN_LS : OWN_IF;
                addr_q  <= ls_req_i ? ls_addr_i : (if_addr_i & ~AW'(7));
                wr_q    <= sel_wr;
                wdata_q <= ls_req_i ? ls_wdata_i : '0;
                strb_q  <= sel_strb;
                rdata_q <= '0;
                err_q   <= ls_req_i & sel_misal;
                cnt_q   <= '0;
            end else if (done) begin
                rdata_q <= mem_rdata_i;
                err_q   <= 1'b0;
            end else if (tmo) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
            if ((state_q == ST_REQ) || (state_q == ST_WAIT)) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        if_gnt_o    = 1'b0;
        if_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        if_err_o    = 1'b0;
        ls_gnt_o    = 1'b0;
        ls_rvalid_o = 1'b0;
        ls_rdata_o  = '0;
        ls_err_o    = 1'b0;
        mem_req_o   = (state_q == ST_REQ);
        mem_wr_o    = mem_req_o & wr_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        mem_wstrb_o = mem_req_o ? strb_q : '0;
        busy_o      = (state_q != ST_IDLE);
        if (mem_req_o && mem_ready_i) begin
            if (own_q == OWN_LS) ls_gnt_o = 1'b1;
            else                 if_gnt_o = 1'b1;
        end
        if (state_q == ST_RESP) begin
            if (own_q == OWN_LS) begin
                ls_rvalid_o = 1'b1;
                ls_rdata_o  = rdata_q;
                ls_err_o    = err_q;
            end else begin
                if_rvalid_o = 1'b1;
                if_rdata_o  = rdata_q;
                if_err_o    = err_q;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040931_mem_arb.sv
// Bench for the IF/LS memory arbiter: vector table, directed
// priority/reset sequences and randomized transactions.
module tb_ysyx_22040931_mem_arb;
    import ysyx_22040931_mem_arb_pkg::*;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o, if_rvalid_o, if_err_o;
    logic [63:0] if_rdata_o;
    logic        ls_req_i, ls_wr_i;
    logic [1:0]  ls_size_i;
    logic [31:0] ls_addr_i;
    logic [63:0] ls_wdata_i;
    logic        ls_gnt_o, ls_rvalid_o, ls_err_o;
    logic [63:0] ls_rdata_o;
    logic        mem_req_o, mem_wr_o;
    logic [31:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic [7:0]  mem_wstrb_o;
    logic        mem_ready_i, mem_rvalid_i;
    logic [63:0] mem_rdata_i;
    logic        busy_o;

    always #5 clk = ~clk;

    ysyx_22040931_mem_arb #(
        .AW(32), .DW(64), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o),
        .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
        .ls_req_i(ls_req_i), .ls_wr_i(ls_wr_i),
        .ls_size_i(ls_size_i), .ls_addr_i(ls_addr_i),
        .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o),
        .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
        .ls_err_o(ls_err_o), .mem_req_o(mem_req_o),
        .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
    );

    typedef struct {
        bit          is_ls;
        bit          wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [63:0] wdata;
        int          rd;
        int          vd;
        logic [63:0] rdata;
        logic [7:0]  e_strb;
        bit          e_err;
        int          e_resp;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, 64'(act), 64'(exp));
    endtask

    // rd = cycles ready held low in REQ, vd = cycles from ready to rvalid.
    function automatic vec_t model(input vec_t v);
        vec_t o = v;
        int bytes = 1 << v.size;
        int off = int'(v.addr % 8);
        bit misal = v.is_ls && ((v.addr % bytes) != 0);
        int n = v.rd + 1 + v.vd;
        logic [31:0] t = 32'((((1 << bytes) - 1) << off));
        o.e_strb = (v.is_ls && v.wr) ? t[7:0] : 8'h00;
        if (misal) begin
            o.e_err = 1'b1;
            o.e_resp = 1;
        end else if (n > TMO) begin
            o.e_err = 1'b1;
            o.e_resp = TMO + 1;
        end else begin
            o.e_err = 1'b0;
            o.e_resp = n + 1;
        end
        return o;
    endfunction

    task automatic idle_inputs();
        if_req_i = 0; if_addr_i = '0;
        ls_req_i = 0; ls_wr_i = 0; ls_size_i = '0;
        ls_addr_i = '0; ls_wdata_i = '0;
        mem_ready_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    endtask

    task automatic chk_quiet(input string nm);
        chk1({nm, " mem_req"}, mem_req_o, 1'b0);
        chk1({nm, " busy"}, busy_o, 1'b0);
        chk1({nm, " ls_rvalid"}, ls_rvalid_o, 1'b0);
        chk1({nm, " if_rvalid"}, if_rvalid_o, 1'b0);
        chk1({nm, " ls_gnt"}, ls_gnt_o, 1'b0);
        chk1({nm, " if_gnt"}, if_gnt_o, 1'b0);
        chk({nm, " mem_addr"}, 64'(mem_addr_o), 64'h0);
        chk({nm, " mem_wstrb"}, 64'(mem_wstrb_o), 64'h0);
        chk({nm, " ls_rdata"}, ls_rdata_o, 64'h0);
        chk({nm, " if_rdata"}, if_rdata_o, 64'h0);
    endtask

    task automatic run_txn(input vec_t v, input string nm);
        bit misal = (v.e_resp == 1);
        int r = v.rd + 1;
        int vk = v.rd + 1 + v.vd;
        int gk = (!misal && r <= TMO) ? r : -1;
        int req_end = misal ? 0 : ((r < TMO) ? r : TMO);
        int holdk = (gk > 0) ? gk : v.e_resp;
        int last = ((misal || vk < v.e_resp) ? v.e_resp : vk) + 2;
        logic [31:0] e_addr = v.is_ls ? v.addr : (v.addr & ~32'h7);
        string s;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            ls_req_i = v.is_ls && (k <= holdk);
            if_req_i = !v.is_ls && (k <= holdk);
            ls_wr_i = v.wr; ls_size_i = v.size;
            ls_addr_i = v.addr; ls_wdata_i = v.wdata;
            if_addr_i = v.addr;
            mem_ready_i = (k == gk);
            mem_rvalid_i = !misal && (k == vk);
            mem_rdata_i = mem_rvalid_i ? v.rdata : {$urandom, $urandom};
            #1;
            s = $sformatf("%s k%0d", nm, k);
            chk1({s, " mem_req"}, mem_req_o, k >= 1 && k <= req_end);
            if (k >= 1 && k <= req_end) begin
                chk({s, " mem_addr"}, 64'(mem_addr_o), 64'(e_addr));
                chk1({s, " mem_wr"}, mem_wr_o, v.is_ls && v.wr);
                chk({s, " mem_wstrb"}, 64'(mem_wstrb_o), 64'(v.e_strb));
                if (v.is_ls && v.wr)
                    chk({s, " mem_wdata"}, mem_wdata_o, v.wdata);
            end
            chk1({s, " ls_gnt"}, ls_gnt_o, v.is_ls && k == gk);
            chk1({s, " if_gnt"}, if_gnt_o, !v.is_ls && k == gk);
            chk1({s, " ls_rvalid"}, ls_rvalid_o, v.is_ls && k == v.e_resp);
            chk1({s, " if_rvalid"}, if_rvalid_o, !v.is_ls && k == v.e_resp);
            chk1({s, " busy"}, busy_o, k >= 1 && k <= v.e_resp);
            if (k == v.e_resp) begin
                if (v.is_ls) begin
                    chk({s, " ls_rdata"}, ls_rdata_o,
                        v.e_err ? 64'h0 : v.rdata);
                    chk1({s, " ls_err"}, ls_err_o, v.e_err);
                end else begin
                    chk({s, " if_rdata"}, if_rdata_o,
                        v.e_err ? 64'h0 : v.rdata);
                    chk1({s, " if_err"}, if_err_o, v.e_err);
                end
            end
        end
        idle_inputs();
    endtask

    vec_t tbl[11];
    vec_t rv;

    initial begin
        //        ls  wr  size    addr           wdata                  rd  vd  rdata                  strb   err resp
        tbl[0]  = '{1, 1, SIZE_H, 32'h8000_0006, 64'h1122_0000_0000_0000, 0, 1, 64'h0,                  8'hC0, 0, 3};
        tbl[1]  = '{1, 0, SIZE_W, 32'h8000_0002, 64'h0,                  0, 0, 64'h5555,               8'h00, 1, 1};
        tbl[2]  = '{0, 0, SIZE_D, 32'h8000_0104, 64'h0,                  3, 4, 64'hDEAD_BEEF_0123_4567, 8'h00, 0, 9};
        tbl[3]  = '{0, 0, SIZE_D, 32'h8000_0104, 64'h0,                  3, 5, 64'hDEAD_BEEF_0123_4567, 8'h00, 1, 9};
        tbl[4]  = '{1, 1, SIZE_B, 32'h8000_0007, 64'hAB00_0000_0000_0000, 0, 0, 64'h77,                 8'h80, 0, 2};
        tbl[5]  = '{1, 1, SIZE_D, 32'h8000_0008, 64'h0102_0304_0506_0708, 1, 2, 64'h0,                  8'hFF, 0, 5};
        tbl[6]  = '{1, 1, SIZE_W, 32'h8000_0004, 64'hCAFE_F00D_0000_0000, 0, 1, 64'h0,                  8'hF0, 0, 3};
        tbl[7]  = '{0, 0, SIZE_D, 32'h8000_0200, 64'h0,                  20, 0, 64'h99,                8'h00, 1, 9};
        tbl[8]  = '{1, 1, SIZE_H, 32'h8000_0003, 64'h0,                  0, 0, 64'h0,                  8'h18, 1, 1};
        tbl[9]  = '{1, 0, SIZE_D, 32'h8000_0040, 64'h0,                  7, 1, 64'h1234,               8'h00, 1, 9};
        tbl[10] = '{1, 0, SIZE_B, 32'h8000_0005, 64'h0,                  0, 2, 64'h0000_0000_0000_ABCD, 8'h00, 0, 4};

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++)
            run_txn(tbl[i], $sformatf("vec%0d", i));

        // Both request together: LS first, IF arbitrated after LS's response.
        for (int k = 0; k <= 8; k++) begin
            string s;
            @(negedge clk);
            ls_req_i = (k <= 1); ls_wr_i = 0; ls_size_i = SIZE_D;
            ls_addr_i = 32'h8000_0010;
            if_req_i = (k <= 5); if_addr_i = 32'h8000_1004;
            mem_ready_i = (k == 1 || k == 5);
            mem_rvalid_i = (k == 2 || k == 6);
            mem_rdata_i = (k == 2) ? 64'hAAAA_0000_0000_1111
                                   : 64'hBBBB_0000_0000_2222;
            #1;
            s = $sformatf("prio k%0d", k);
            chk1({s, " mem_req"}, mem_req_o, k == 1 || k == 5);
            chk1({s, " ls_gnt"}, ls_gnt_o, k == 1);
            chk1({s, " if_gnt"}, if_gnt_o, k == 5);
            chk1({s, " ls_rvalid"}, ls_rvalid_o, k == 3);
            chk1({s, " if_rvalid"}, if_rvalid_o, k == 7);
            if (k == 1) chk({s, " addr"}, 64'(mem_addr_o), 64'h8000_0010);
            if (k == 5) chk({s, " addr"}, 64'(mem_addr_o), 64'h8000_1000);
            if (k == 3) chk({s, " ls_rdata"}, ls_rdata_o, 64'hAAAA_0000_0000_1111);
            if (k == 7) chk({s, " if_rdata"}, if_rdata_o, 64'hBBBB_0000_0000_2222);
        end
        idle_inputs();
        @(negedge clk);

        // Reset asserted while waiting for the response.
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            ls_req_i = (k <= 1); ls_wr_i = 1; ls_size_i = SIZE_D;
            ls_addr_i = 32'h8000_0020; ls_wdata_i = 64'h5A5A;
            mem_ready_i = (k == 1);
            if (k == 3) rst_n = 1'b0;
            #1;
            if (k == 2) chk1("rst busy in wait", busy_o, 1'b1);
        end
        chk_quiet("rst mid-wait");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rst_n = 1'b1;
            ls_req_i = 0;
            mem_ready_i = 0;
            mem_rvalid_i = (k < 2);
            mem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
            #1;
            chk_quiet($sformatf("post-rst k%0d", k));
        end
        idle_inputs();

        for (int i = 0; i < 40; i++) begin
            rv.is_ls = 1'($urandom_range(0, 1));
            rv.wr = 1'($urandom_range(0, 1));
            rv.size = 2'($urandom_range(0, 3));
            rv.addr = 32'h8000_0000 | ($urandom & 32'h0000_FFF8)
                    | 32'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1)
                rv.addr = rv.addr & ~(32'(1 << rv.size) - 32'd1);
            rv.wdata = {$urandom, $urandom};
            rv.rdata = {$urandom, $urandom};
            rv.rd = $urandom_range(0, 3);
            rv.vd = $urandom_range(0, 4);
            if ($urandom_range(0, 7) == 0) rv.rd = $urandom_range(4, 9);
            rv = model(rv);
            run_txn(rv, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
